morra_cinese: RTL and testbench
===============================

Name: morra_cinese

Overview:
- Sequential game controller (FSM plus datapath) for rock-paper-scissors ("morra cinese") between two players.
- At game start it latches the maximum number of rounds ("manche").
- Each clock it judges the two players' moves, enforces the no-repeat rule, tracks scores and reports round and match results.
- Top-level block of the game design, driven directly by player inputs.

Parameters:
- MIN_MANCHE, 4, minimum number of valid rounds before an early match end is allowed; also the offset added to the configured maximum.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- INIZIO  input  1  start/restart; when 1 the cycle is a configuration cycle.
- PRIMO  input  2  player 1 move; on a configuration cycle, upper 2 bits of the round limit.
- SECONDO  input  2  player 2 move; on a configuration cycle, lower 2 bits of the round limit.
- MANCHE  output  2  round result, registered.
- PARTITA  output  2  match result, registered.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Move encoding: 00 = no move, 01 = rock, 10 = paper, 11 = scissors.
- Beat relations: rock beats scissors, scissors beats paper, paper beats rock.
- MANCHE codes: 00 = invalid round, 01 = P1 wins, 10 = P2 wins, 11 = tie.
- PARTITA codes: 00 = match in progress / none, 01 = P1 wins match, 10 = P2 wins match, 11 = match tie.
- Reset: state IDLE; MANCHE=00, PARTITA=00; all counters 0; no forbidden move.
- Timing: inputs are sampled at the rising edge; outputs update on that same edge (one-cycle latency) and hold until the next edge.
- States: IDLE, PLAY, DONE.
- INIZIO=1 (any state, highest priority):
  - max_manche = {PRIMO,SECONDO} + 4, range 4..19, stored in 5 bits.
  - Clear win counters and round counter; clear the forbidden-move record.
  - Go to PLAY; MANCHE=00, PARTITA=00.
- IDLE with INIZIO=0: moves ignored; outputs 00/00.
- PLAY with INIZIO=0, round validity:
  - A round is invalid if either move is 00.
  - A round is invalid if the winner of the last valid decided round replays the move they won with. Only that player is restricted, and only that exact move.
  - Invalid round: MANCHE=00; counters, forbidden record and PARTITA unchanged.
- PLAY, valid round:
  - MANCHE = result code; round count +1.
  - Winner's count +1 and its winning move becomes forbidden for that player.
  - A tie clears any forbidden record.
- Match end, evaluated on the same edge using the updated counts:
  - If round count >= MIN_MANCHE and |w1-w2| >= 2: PARTITA = leader (01/10); go to DONE.
  - Else if round count == max_manche: PARTITA = 01 if w1>w2, 10 if w2>w1, 11 if equal; go to DONE.
  - Otherwise PARTITA=00.
- DONE with INIZIO=0: moves ignored; MANCHE=00; PARTITA holds the final result until INIZIO or reset.
- Counters are 5 bits and never exceed 19, so no wrap-around is possible.
- rst_n asserted mid-game: immediate return to reset values regardless of clock.

Decomposition:
- Shared package morra_pkg holds:
  - move typedef and encodings (NONE, ROCK, PAPER, SCISSORS);
  - manche/partita result codes;
  - state enum (IDLE, PLAY, DONE);
  - MIN_MANCHE constant.
- One sub-module, morra_judge: combinational; inputs are the two moves plus the forbidden move and forbidden player; outputs are a valid flag and the round result.
- FSM, counters and end detection live in morra_cinese.

Test Plan:
- Reset then INIZIO=1, PRIMO=00, SECONDO=00 -> max_manche=4; outputs 00/00.
- After that start: PRIMO=10, SECONDO=01 -> MANCHE=01, PARTITA=00. Then:
  - PRIMO=10, SECONDO=11 -> MANCHE=00 (P1 repeats winning paper);
  - PRIMO=10, SECONDO=00 -> 00;
  - PRIMO=10, SECONDO=11 -> 00;
  - PRIMO=10, SECONDO=01 -> 00;
  - PARTITA stays 00 throughout.
- max=4; P1 wins rounds 1 and 3, P2 wins round 2, then P1 wins round 4 -> after round 4 PARTITA=01 (diff 2), state DONE. Further moves -> MANCHE=00, PARTITA remains 01.
- INIZIO=1 with PRIMO=11, SECONDO=11 (max 19), then 19 alternating ties -> MANCHE=11 each round; PARTITA=11 after round 19.
- P1 leads 3-0 with only 3 rounds played -> PARTITA stays 00 until a 4th valid round. Invalid round at a tie score -> no counter change.
- rst_n pulsed low mid-match -> outputs 00/00 immediately; moves ignored until INIZIO=1.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared types and constants for the rock-paper-scissors (morra cinese) game controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package morra_pkg;

  // Player move encoding; NONE means the player has not shown a hand
  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } move_t;

  // Round result codes (MANCHE); P1/P2 codes also tag the forbidden-move owner
  localparam logic [1:0] RES_INVALID = 2'b00;
  localparam logic [1:0] RES_P1      = 2'b01;
  localparam logic [1:0] RES_P2      = 2'b10;
  localparam logic [1:0] RES_TIE     = 2'b11;

  // Match result codes (PARTITA)
  localparam logic [1:0] MATCH_NONE = 2'b00;
  localparam logic [1:0] MATCH_P1   = 2'b01;
  localparam logic [1:0] MATCH_P2   = 2'b10;
  localparam logic [1:0] MATCH_TIE  = 2'b11;

  // Game controller states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Minimum valid rounds before an early end; also the round-limit offset
  localparam int MIN_MANCHE = 4;

  // True when move a beats move b (rock > scissors > paper > rock)
  function automatic logic beats(input move_t a, input move_t b);
    return ((a == ROCK)     && (b == SCISSORS)) ||
           ((a == SCISSORS) && (b == PAPER))    ||
           ((a == PAPER)    && (b == ROCK));
  endfunction

endpackage

// File: rtl/morra_judge.sv
// Judges one round: validity (missing hand, forbidden replay) and the round winner.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates whatever moves are presented.
module morra_judge
  import morra_pkg::*;
(
  input  move_t      p1_move,
  input  move_t      p2_move,
  input  move_t      forb_move,
  input  logic [1:0] forb_player,
  output logic       valid,
  output logic [1:0] result
);

  logic missing;
  logic p1_blocked;
  logic p2_blocked;
  logic [1:0] outcome;

  // Only the last winner is restricted, and only from the exact move it won with
  always_comb begin
    missing    = (p1_move == NONE) || (p2_move == NONE);
    p1_blocked = (forb_player == RES_P1) && (p1_move == forb_move);
    p2_blocked = (forb_player == RES_P2) && (p2_move == forb_move);

    if (p1_move == p2_move)
      outcome = RES_TIE;
    else if (beats(p1_move, p2_move))
      outcome = RES_P1;
    else
      outcome = RES_P2;

    valid  = !missing && !p1_blocked && !p2_blocked;
    result = valid ? outcome : RES_INVALID;
  end

endmodule

// File: rtl/morra_cinese.sv
// Rock-paper-scissors match controller: round limit config, scoring, no-repeat rule, match end.
// Latency: one cycle; MANCHE/PARTITA are registered on the edge that samples the moves.
// Backpressure: none; inputs are consumed every cycle, INIZIO restarts from any state.
module morra_cinese
  import morra_pkg::*;
#(
  parameter int MIN_MANCHE = morra_pkg::MIN_MANCHE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INIZIO,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);

  state_t     state;
  logic [4:0] max_manche;
  logic [4:0] rounds;
  logic [4:0] wins1;
  logic [4:0] wins2;
  move_t      forb_move;
  logic [1:0] forb_player;

  logic       rnd_valid;
  logic [1:0] rnd_result;
  logic [4:0] rounds_nxt;
  logic [4:0] wins1_nxt;
  logic [4:0] wins2_nxt;
  logic       lead1;
  logic       lead2;
  logic       early_ok;
  logic       limit_hit;
  move_t      win_move;

  morra_judge u_judge (
    .p1_move     (move_t'(PRIMO)),
    .p2_move     (move_t'(SECONDO)),
    .forb_move   (forb_move),
    .forb_player (forb_player),
    .valid       (rnd_valid),
    .result      (rnd_result)
  );

  // Post-round scores and end conditions, assuming this round turns out valid
  always_comb begin
    rounds_nxt = rounds + 5'd1;
    wins1_nxt  = wins1 + {4'd0, (rnd_result == RES_P1)};
    wins2_nxt  = wins2 + {4'd0, (rnd_result == RES_P2)};
    lead1      = wins1_nxt >= (wins2_nxt + 5'd2);
    lead2      = wins2_nxt >= (wins1_nxt + 5'd2);
    early_ok   = rounds_nxt >= 5'(MIN_MANCHE);
    limit_hit  = rounds_nxt == max_manche;
    win_move   = (rnd_result == RES_P1) ? move_t'(PRIMO) : move_t'(SECONDO);
  end

  // Game FSM with counters, forbidden-move record and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      max_manche  <= 5'd0;
      rounds      <= 5'd0;
      wins1       <= 5'd0;
      wins2       <= 5'd0;
      forb_move   <= NONE;
      forb_player <= RES_INVALID;
      MANCHE      <= RES_INVALID;
      PARTITA     <= MATCH_NONE;
    end else if (INIZIO) begin
      state       <= PLAY;
      max_manche  <= {1'b0, PRIMO, SECONDO} + 5'(MIN_MANCHE);
      rounds      <= 5'd0;
      wins1       <= 5'd0;
      wins2       <= 5'd0;
      forb_move   <= NONE;
      forb_player <= RES_INVALID;
      MANCHE      <= RES_INVALID;
      PARTITA     <= MATCH_NONE;
    end else begin
      case (state)
        PLAY: begin
          if (!rnd_valid) begin
            MANCHE <= RES_INVALID;
          end else begin
            MANCHE <= rnd_result;
            rounds <= rounds_nxt;
            wins1  <= wins1_nxt;
            wins2  <= wins2_nxt;
            if (rnd_result == RES_TIE) begin
              forb_move   <= NONE;
              forb_player <= RES_INVALID;
            end else begin
              forb_move   <= win_move;
              forb_player <= rnd_result;
            end
            if (early_ok && (lead1 || lead2)) begin
              PARTITA <= lead1 ? MATCH_P1 : MATCH_P2;
              state   <= DONE;
            end else if (limit_hit) begin
              if (wins1_nxt > wins2_nxt)
                PARTITA <= MATCH_P1;
              else if (wins2_nxt > wins1_nxt)
                PARTITA <= MATCH_P2;
              else
                PARTITA <= MATCH_TIE;
              state <= DONE;
            end else begin
              PARTITA <= MATCH_NONE;
            end
          end
        end
        DONE: begin
          MANCHE <= RES_INVALID;
        end
        default: begin
          MANCHE  <= RES_INVALID;
          PARTITA <= MATCH_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morra_cinese.sv
module tb_morra_cinese;

  logic       clk;
  logic       rst_n;
  logic       INIZIO;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  logic [3:0] exp_q[$];
  int         tag_q[$];

  morra_cinese #(.MIN_MANCHE(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INIZIO  (INIZIO),
    .PRIMO   (PRIMO),
    .SECONDO (SECONDO),
    .MANCHE  (MANCHE),
    .PARTITA (PARTITA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int tag,
                       input logic [1:0] m, input logic [1:0] p,
                       input logic [1:0] em, input logic [1:0] ep);
    checks++;
    if (m !== em || p !== ep) begin
      errors++;
      $display("FAIL %s step %0d: got MANCHE=%b PARTITA=%b, want MANCHE=%b PARTITA=%b",
               name, tag, m, p, em, ep);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic ini, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] em, input logic [1:0] ep);
    @(negedge clk);
    INIZIO  = ini;
    PRIMO   = a;
    SECONDO = b;
    exp_q.push_back({em, ep});
    tag_q.push_back(step_no);
    step_no++;
    @(posedge clk);
  endtask

  // Monitor: compare registered outputs just after each edge against the scoreboard
  always @(posedge clk) begin
    logic [3:0] e;
    int t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check("scoreboard", t, MANCHE, PARTITA, e[3:2], e[1:0]);
    end
  end

  initial begin
    int waited;
    rst_n   = 1'b0;
    INIZIO  = 1'b0;
    PRIMO   = 2'b00;
    SECONDO = 2'b00;
    #12;
    check("reset_state", -1, MANCHE, PARTITA, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores moves
    step(0, 2'b01, 2'b11, 2'b00, 2'b00);

    // Start with max 4; P1 wins with paper then replays it
    step(1, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b10, 2'b01, 2'b01, 2'b00);
    step(0, 2'b10, 2'b11, 2'b00, 2'b00);
    step(0, 2'b10, 2'b00, 2'b00, 2'b00);
    step(0, 2'b10, 2'b11, 2'b00, 2'b00);
    step(0, 2'b10, 2'b01, 2'b00, 2'b00);

    // Max 4: P1, P2, P1, P1 -> 3-1 after round 4, P1 wins the match
    step(1, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b01, 2'b11, 2'b01, 2'b00);
    step(0, 2'b10, 2'b11, 2'b10, 2'b00);
    step(0, 2'b11, 2'b10, 2'b01, 2'b00);
    step(0, 2'b01, 2'b11, 2'b01, 2'b01);
    step(0, 2'b01, 2'b10, 2'b00, 2'b01);
    step(0, 2'b10, 2'b01, 2'b00, 2'b01);

    // Max 19, nineteen alternating ties -> match tie at the limit
    step(1, 2'b11, 2'b11, 2'b00, 2'b00);
    for (int i = 1; i <= 19; i++) begin
      if (i[0]) step(0, 2'b01, 2'b01, 2'b11, (i == 19) ? 2'b11 : 2'b00);
      else      step(0, 2'b10, 2'b10, 2'b11, 2'b00);
    end
    step(0, 2'b01, 2'b01, 2'b00, 2'b11);

    // Max 8: P1 3-0 after 3 rounds stays open; ends on the 4th valid round
    step(1, 2'b01, 2'b00, 2'b00, 2'b00);
    step(0, 2'b01, 2'b11, 2'b01, 2'b00);
    step(0, 2'b10, 2'b01, 2'b01, 2'b00);
    step(0, 2'b11, 2'b10, 2'b01, 2'b00);
    step(0, 2'b11, 2'b10, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00, 2'b00, 2'b00);
    step(0, 2'b01, 2'b10, 2'b10, 2'b01);

    // Max 4: invalid round at 0-0 must not count; limit reached on 4th tie
    step(1, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00, 2'b00, 2'b00);
    step(0, 2'b01, 2'b01, 2'b11, 2'b00);
    step(0, 2'b00, 2'b10, 2'b00, 2'b00);
    step(0, 2'b10, 2'b10, 2'b11, 2'b00);
    step(0, 2'b11, 2'b11, 2'b11, 2'b00);
    step(0, 2'b01, 2'b01, 2'b11, 2'b11);

    // Mid-match asynchronous reset
    step(1, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b01, 2'b11, 2'b01, 2'b00);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", step_no, MANCHE, PARTITA, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 2'b01, 2'b11, 2'b00, 2'b00);
    step(0, 2'b10, 2'b01, 2'b00, 2'b00);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b11, 2'b10, 2'b01, 2'b00);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
